// File: rtl/shift_pkg.sv
// Shared types and default sizing for the shift sequencer and its timebase.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DIV   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_STORE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/shift_timebase.sv
// DIV-cycle phase divider: phase_end is high on the last cycle of each phase,
// and the count restarts whenever the sequencer changes state.
module shift_timebase
  import shift_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase_end
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign phase_end = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || phase_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Drives an external parallel-in chain (read) and serial-in chain (write)
// with a shared divided shift clock; one transaction at a time.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_read,
  input  logic             go_write,
  input  logic [WIDTH-1:0] write_data,
  input  logic             serial_in,
  output logic             ready,
  output logic             shift_clk,
  output logic             serial_out,
  output logic             load_n,
  output logic             store,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             is_read_q, is_read_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic             ready_q, ready_d;
  logic             shift_clk_q, shift_clk_d;
  logic             serial_out_q, serial_out_d;
  logic             load_n_q, load_n_d;
  logic             store_q, store_d;
  logic             read_valid_q, read_valid_d;
  logic             phase_end;
  logic             restart;

  assign restart = (state_d != state_q);

  shift_timebase #(.DIV(DIV)) u_timebase (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    bit_d       = bit_q;
    sreg_d      = sreg_q;
    read_data_d = read_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go_read) begin
          state_d   = ST_LOAD;
          is_read_d = 1'b1;
          sreg_d    = '0;
          bit_d     = '0;
        end else if (go_write) begin
          state_d   = ST_SHIFT_LO;
          is_read_d = 1'b0;
          sreg_d    = write_data;
          bit_d     = '0;
        end
      end
      ST_LOAD: begin
        if (phase_end) begin
          state_d = ST_SHIFT_LO;
          bit_d   = '0;
        end
      end
      ST_SHIFT_LO: begin
        // Sample just before shift_clk rises so the chain output is settled.
        if (phase_end) begin
          state_d = ST_SHIFT_HI;
          if (is_read_q) begin
            sreg_d = {sreg_q[WIDTH-2:0], serial_in};
          end
        end
      end
      ST_SHIFT_HI: begin
        if (phase_end) begin
          if (!is_read_q) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          end
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (is_read_q) begin
              state_d     = ST_DONE;
              read_data_d = sreg_q;
            end else begin
              state_d = ST_STORE;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_STORE: begin
        if (phase_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    ready_d      = (state_d == ST_IDLE);
    shift_clk_d  = (state_d == ST_SHIFT_HI);
    load_n_d     = (state_d != ST_LOAD);
    store_d      = (state_d == ST_STORE);
    read_valid_d = (state_d == ST_DONE) && is_read_d;
    serial_out_d = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI))
                   && !is_read_d && sreg_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      is_read_q    <= 1'b0;
      bit_q        <= '0;
      sreg_q       <= '0;
      read_data_q  <= '0;
      ready_q      <= 1'b1;
      shift_clk_q  <= 1'b0;
      serial_out_q <= 1'b0;
      load_n_q     <= 1'b1;
      store_q      <= 1'b0;
      read_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_read_q    <= is_read_d;
      bit_q        <= bit_d;
      sreg_q       <= sreg_d;
      read_data_q  <= read_data_d;
      ready_q      <= ready_d;
      shift_clk_q  <= shift_clk_d;
      serial_out_q <= serial_out_d;
      load_n_q     <= load_n_d;
      store_q      <= store_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign ready      = ready_q;
  assign shift_clk  = shift_clk_q;
  assign serial_out = serial_out_q;
  assign load_n     = load_n_q;
  assign store      = store_q;
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer at WIDTH=8, DIV=2 with a behavioural
// parallel-in read chain; cycle c = values visible after go edge c-1.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       go_read;
  logic       go_write;
  logic [7:0] write_data;
  logic       serial_in;
  logic       ready;
  logic       shift_clk;
  logic       serial_out;
  logic       load_n;
  logic       store;
  logic [7:0] read_data;
  logic       read_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction statistics gathered by run_txn
  int         load_cnt, load_first, load_last;
  int         rises, store_cnt;
  int         valid_cnt, valid_first, valid_last;
  int         ready_cnt, ready_first;
  logic [7:0] ser_bits;

  // External parallel-in shift chain feeding serial_in
  logic [7:0] chain_word = 8'h00;
  logic [7:0] chain = 8'h00;
  logic       sclk_seen = 1'b0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .DIV(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .go_read    (go_read),
    .go_write   (go_write),
    .write_data (write_data),
    .serial_in  (serial_in),
    .ready      (ready),
    .shift_clk  (shift_clk),
    .serial_out (serial_out),
    .load_n     (load_n),
    .store      (store),
    .read_data  (read_data),
    .read_valid (read_valid)
  );

  always @(posedge clk) begin
    if (!load_n) chain <= chain_word;
    else if (shift_clk && !sclk_seen) chain <= {chain[6:0], 1'b0};
    sclk_seen <= shift_clk;
  end

  assign serial_in = chain[7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; the go edge is cycle 0.
  task automatic run_txn(input logic rd, input logic wr, input logic [7:0] wd,
                         input logic [7:0] word, input int ncyc, input int pulse_cyc,
                         input logic hold);
    logic prev_sclk;
    chain_word = word;
    go_read = rd; go_write = wr; write_data = wd;
    load_cnt = 0; load_first = 0; load_last = 0; rises = 0; store_cnt = 0;
    valid_cnt = 0; valid_first = 0; valid_last = 0; ready_cnt = 0; ready_first = 0;
    ser_bits = 8'h00; prev_sclk = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      #1;
      if (!load_n) begin
        load_cnt++;
        if (load_first == 0) load_first = c;
        load_last = c;
      end
      if (shift_clk && !prev_sclk) begin
        rises++;
        ser_bits = {ser_bits[6:0], serial_out};
      end
      prev_sclk = shift_clk;
      if (store) store_cnt++;
      if (read_valid) begin
        valid_cnt++;
        if (valid_first == 0) valid_first = c;
        valid_last = c;
      end
      if (ready) begin
        ready_cnt++;
        if (ready_first == 0) ready_first = c;
      end
      if (!hold || c == ncyc) begin
        go_read = 1'b0;
        go_write = (c == pulse_cyc);
      end
      @(posedge clk);
    end
    #1;
    go_write = 1'b0;
    $display("txn rd=%0b wr=%0b wd=%02h chain=%02h: valid@%0d ready@%0d store=%0d bits=%02h rdata=%02h",
             rd, wr, wd, word, valid_first, ready_first, store_cnt, ser_bits, read_data);
  endtask

  initial begin
    reset = 1'b1; go_read = 1'b0; go_write = 1'b0; write_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_shift_clk", {31'd0, shift_clk}, 32'd0);
    check("rst_serial_out", {31'd0, serial_out}, 32'd0);
    check("rst_load_n", {31'd0, load_n}, 32'd1);
    check("rst_store", {31'd0, store}, 32'd0);
    check("rst_read_data", {24'd0, read_data}, 32'h0);
    check("rst_read_valid", {31'd0, read_valid}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Plain read of 8'hA5
    run_txn(1'b1, 1'b0, 8'h00, 8'hA5, 40, 0, 1'b0);
    check("rd_load_cnt", load_cnt, 2);
    check("rd_load_first", load_first, 1);
    check("rd_load_last", load_last, 2);
    check("rd_sclk_pulses", rises, 8);
    check("rd_valid_cnt", valid_cnt, 1);
    check("rd_valid_cycle", valid_first, 35);
    check("rd_data", {24'd0, read_data}, 32'hA5);
    check("rd_ready_cycle", ready_first, 36);
    check("rd_store_cnt", store_cnt, 0);

    // Write of 8'h3C
    run_txn(1'b0, 1'b1, 8'h3C, 8'h00, 40, 0, 1'b0);
    check("wr_bits", {24'd0, ser_bits}, 32'h3C);
    check("wr_sclk_pulses", rises, 8);
    check("wr_store_cnt", store_cnt, 2);
    check("wr_ready_cycle", ready_first, 36);
    check("wr_load_cnt", load_cnt, 0);
    check("wr_valid_cnt", valid_cnt, 0);
    check("wr_rdata_hold", {24'd0, read_data}, 32'hA5);

    // Simultaneous go: read wins, write dropped
    run_txn(1'b1, 1'b1, 8'hFF, 8'h5A, 40, 0, 1'b0);
    check("both_store_cnt", store_cnt, 0);
    check("both_valid_cycle", valid_first, 35);
    check("both_rdata", {24'd0, read_data}, 32'h5A);
    check("both_ready_cycle", ready_first, 36);

    // go_write pulsed during SHIFT_HI (cycle 10) of a read
    run_txn(1'b1, 1'b0, 8'h00, 8'hC3, 50, 10, 1'b0);
    check("ign_valid_cnt", valid_cnt, 1);
    check("ign_store_cnt", store_cnt, 0);
    check("ign_rdata", {24'd0, read_data}, 32'hC3);
    check("ign_ready_cnt", ready_cnt, 15);

    // Back-to-back reads with go_read held high
    run_txn(1'b1, 1'b0, 8'h00, 8'h96, 72, 0, 1'b1);
    check("b2b_valid_cnt", valid_cnt, 2);
    check("b2b_valid_first", valid_first, 35);
    check("b2b_valid_second", valid_last, 71);
    check("b2b_ready_cnt", ready_cnt, 2);
    check("b2b_ready_first", ready_first, 36);
    check("b2b_rdata", {24'd0, read_data}, 32'h96);

    // Reset during bit 4 of a write (cycle 18 is in its SHIFT_LO)
    go_write = 1'b1; write_data = 8'hF0;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      #1;
      go_write = 1'b0;
      if (c == 18) reset = 1'b1;
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    check("mid_ready", {31'd0, ready}, 32'd1);
    check("mid_shift_clk", {31'd0, shift_clk}, 32'd0);
    check("mid_serial_out", {31'd0, serial_out}, 32'd0);
    check("mid_load_n", {31'd0, load_n}, 32'd1);
    check("mid_store", {31'd0, store}, 32'd0);
    check("mid_read_data", {24'd0, read_data}, 32'h0);
    check("mid_read_valid", {31'd0, read_valid}, 32'd0);
    $display("txn reset during write bit 4: ready=%0b read_data=%02h", ready, read_data);

    run_txn(1'b1, 1'b0, 8'h00, 8'hA5, 40, 0, 1'b0);
    check("post_store_cnt", store_cnt, 0);
    check("post_valid_cnt", valid_cnt, 1);
    check("post_valid_cycle", valid_first, 35);
    check("post_rdata", {24'd0, read_data}, 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, bits per shift transaction (WIDTH >= 2).
REQ-002 Parameter DIV, default 4, clk cycles per shift_clk half-period (DIV >= 1).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 go_read  input  1  request a read transaction (parallel-load, shift in).
REQ-006 go_write  input  1  request a write transaction (shift out, store).
REQ-007 write_data  input  WIDTH  word to shift out; captured when a write is accepted.
REQ-008 serial_in  input  1  serial data from external parallel-in shift chain.
REQ-009 ready  output  1  high only in IDLE; a go is accepted only while ready.
REQ-010 shift_clk  output  1  shift clock to both external chains.
REQ-011 serial_out  output  1  serial data to external serial-in chain, MSB first.
REQ-012 load_n  output  1  active-low parallel-load strobe for the read chain.
REQ-013 store  output  1  active-high output-latch strobe for the write chain.
REQ-014 read_data  output  WIDTH  last completed read word, MSB = first bit received.
REQ-015 read_valid  output  1  one-cycle pulse when read_data updates.

Function
REQ-016 States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, STORE, DONE; all outputs registered.
REQ-017 IDLE: ready=1; go_read=1 -> LOAD (read); else go_write=1 -> SHIFT_LO (write), write_data captured same edge.
REQ-018 go_read and go_write high in same IDLE cycle: read wins; write is dropped, not queued.
REQ-019 go_read/go_write outside IDLE are ignored; no pending flag retained.
REQ-020 LOAD: load_n=0 for exactly DIV cycles, then SHIFT_LO with bit counter = 0.
REQ-021 SHIFT_LO: shift_clk=0 for DIV cycles; SHIFT_HI: shift_clk=1 for DIV cycles; one LO+HI pair = one bit.
REQ-022 Read: serial_in sampled into the shift register LSB (shift left) on the last cycle of each SHIFT_LO.
REQ-023 Write: serial_out = current MSB of the captured word throughout SHIFT_LO and SHIFT_HI; word shifts left at the end of SHIFT_HI.
REQ-024 After SHIFT_HI of bit WIDTH-1 (counter wraps WIDTH-1 -> 0): read -> DONE; write -> STORE.
REQ-025 STORE: store=1 for exactly DIV cycles, then DONE.
REQ-026 DONE: one cycle; read: read_data <= shift register and read_valid=1; write: no data output; then IDLE.
REQ-027 Read latency: go sampled at edge N -> read_valid at cycle N+DIV+2*DIV*WIDTH+1; write returns to ready after DIV*(2*WIDTH+1)+1 cycles.
REQ-028 Bit counter width = clog2(WIDTH); divider counter width = clog2(DIV), or 1 bit if DIV = 1.
REQ-029 read_data holds its value across write transactions and across idle time.

Reset
REQ-030 Reset applies at the next clk edge from any state, including mid-shift; the aborted transaction produces no read_valid or store.
REQ-031 Reset values: state=IDLE, ready=1, shift_clk=0, serial_out=0, load_n=1, store=0, read_data=0, read_valid=0, counters=0.

Structure
REQ-032 Shared package shift_pkg: state enumeration and default WIDTH/DIV constants.
REQ-033 One sub-module, shift_timebase: DIV-cycle divider emitting a one-cycle phase_end tick, restarted on every state change.
REQ-034 The existing go/ready/shift-clock arbitration is superseded for the read and write chains served by this block.

Verification (WIDTH=8, DIV=2)
REQ-035 Read: chain presents 8'hA5, go_read at edge 0 -> load_n low cycles 1-2, 8 shift_clk pulses, read_data=8'hA5, read_valid high only at cycle 35.
REQ-036 Write: write_data=8'h3C, go_write -> serial_out 0,0,1,1,1,1,0,0 at the 8 shift_clk rising edges, store high 2 cycles, ready returns after 35 cycles.
REQ-037 Simultaneous go_read=1, go_write=1 in IDLE -> read performed only; no store pulse; ready after read completes.
REQ-038 go_write pulsed during SHIFT_HI of a read -> ignored; exactly one transaction; read_data unaffected.
REQ-039 Reset asserted during bit 4 of a write -> next cycle all outputs at reset values, no store pulse; subsequent go_read completes normally.
REQ-040 Back-to-back: go_read held high continuously -> successive reads separated by exactly one IDLE cycle, read_valid once per read.
